// File: rtl/ifu_fetch.sv
// Instruction fetch-request stage: takes one PC from the IFU, issues a single outstanding
// instruction-memory read and hands {pc, inst, fault} to the IDU over valid/ready.
module ifu_fetch #(
    parameter int                ADDR_W      = 32,
    parameter int                INST_W      = 32,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [INST_W-1:0] NOP_INST    = 32'h0000_0013
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_ifu_valid,
    output logic              o_ifu_ready,
    input  logic [ADDR_W-1:0] i_ifu_pc,
    input  logic              i_exu_jmp_en,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [ADDR_W-1:0] o_imem_req_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_data,
    input  logic              i_imem_rsp_err,
    output logic              o_idu_valid,
    input  logic              i_idu_ready,
    output logic [ADDR_W-1:0] o_idu_pc,
    output logic [INST_W-1:0] o_idu_inst,
    output logic              o_idu_fault
);

    localparam int                TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_fault;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_orphan;

    logic ifu_acc;
    logic req_fire;
    logic tmo_hit;
    logic rsp_take;

    assign o_ifu_ready      = (r_state == S_IDLE) | ((r_state == S_HOLD) & i_idu_ready) | i_exu_jmp_en;
    assign ifu_acc          = i_ifu_valid & o_ifu_ready & ~i_exu_jmp_en;
    // Requests stay blocked until the response owed to an abandoned fetch has drained.
    assign o_imem_req_valid = (r_state == S_REQ) & ~r_orphan;
    assign req_fire         = o_imem_req_valid & i_imem_req_ready;
    assign tmo_hit          = (r_tmo == TMO_MAX);
    assign rsp_take         = i_imem_rsp_valid & ~r_orphan;

    assign o_idu_valid      = (r_state == S_HOLD) & ~i_exu_jmp_en;
    assign o_idu_pc         = r_pc;
    assign o_idu_inst       = r_inst;
    assign o_idu_fault      = r_fault;
    assign o_imem_req_addr  = r_pc;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_inst   <= '0;
            r_fault  <= 1'b0;
            r_tmo    <= '0;
            r_orphan <= 1'b0;
        end else begin
            // A response that is owed but no longer wanted is tracked so it can be dropped later.
            if (r_orphan && i_imem_rsp_valid) begin
                r_orphan <= 1'b0;
            end else if (i_exu_jmp_en && req_fire) begin
                r_orphan <= 1'b1;
            end else if ((r_state == S_WAIT) && !i_imem_rsp_valid && (i_exu_jmp_en || tmo_hit)) begin
                r_orphan <= 1'b1;
            end

            if (i_exu_jmp_en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_HOLD: begin
                        if (ifu_acc) begin
                            r_pc <= i_ifu_pc;
                            if (i_ifu_pc[1:0] != 2'b00) begin
                                r_state <= S_HOLD;
                                r_fault <= 1'b1;
                                r_inst  <= NOP_INST;
                            end else begin
                                r_state <= S_REQ;
                            end
                        end else if ((r_state == S_HOLD) && i_idu_ready) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_REQ: begin
                        if (req_fire) begin
                            r_state <= S_WAIT;
                            r_tmo   <= '0;
                        end
                    end
                    S_WAIT: begin
                        r_tmo <= r_tmo + 1'b1;
                        if (rsp_take) begin
                            r_state <= S_HOLD;
                            r_fault <= i_imem_rsp_err;
                            r_inst  <= i_imem_rsp_err ? NOP_INST : i_imem_rsp_data;
                        end else if (tmo_hit) begin
                            r_state <= S_HOLD;
                            r_fault <= 1'b1;
                            r_inst  <= NOP_INST;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: one vector per clock cycle of inputs and expected outputs,
// with a short timeout window so the timeout and stray-response paths are reachable.
module tb_ifu_fetch;

    logic        i_sys_clk = 1'b0;
    logic        i_sys_rst = 1'b1;
    logic        i_ifu_valid = 1'b0;
    logic        o_ifu_ready;
    logic [31:0] i_ifu_pc = '0;
    logic        i_exu_jmp_en = 1'b0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b1;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        i_imem_rsp_err = 1'b0;
    logic        o_idu_valid;
    logic        i_idu_ready = 1'b1;
    logic [31:0] o_idu_pc;
    logic [31:0] o_idu_inst;
    logic        o_idu_fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_sys_clk = ~i_sys_clk;

    ifu_fetch #(
        .ADDR_W(32),
        .INST_W(32),
        .TIMEOUT_CYC(4),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .i_sys_clk(i_sys_clk),
        .i_sys_rst(i_sys_rst),
        .i_ifu_valid(i_ifu_valid),
        .o_ifu_ready(o_ifu_ready),
        .i_ifu_pc(i_ifu_pc),
        .i_exu_jmp_en(i_exu_jmp_en),
        .o_imem_req_valid(o_imem_req_valid),
        .i_imem_req_ready(i_imem_req_ready),
        .o_imem_req_addr(o_imem_req_addr),
        .i_imem_rsp_valid(i_imem_rsp_valid),
        .i_imem_rsp_data(i_imem_rsp_data),
        .i_imem_rsp_err(i_imem_rsp_err),
        .o_idu_valid(o_idu_valid),
        .i_idu_ready(i_idu_ready),
        .o_idu_pc(o_idu_pc),
        .o_idu_inst(o_idu_inst),
        .o_idu_fault(o_idu_fault)
    );

    typedef struct {
        string       name;
        logic        ifu_v;
        logic [31:0] pc;
        logic        jmp;
        logic        req_rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        rsp_e;
        logic        idu_rdy;
        logic        e_ifu_rdy;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_idu_v;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_fault;
    } vec_t;

    function automatic vec_t mk(input string name, input logic ifu_v, input logic [31:0] pc,
                                input logic jmp, input logic req_rdy, input logic rsp_v,
                                input logic [31:0] rsp_d, input logic rsp_e, input logic idu_rdy,
                                input logic e_ifu_rdy, input logic e_req_v, input logic [31:0] e_addr,
                                input logic e_idu_v, input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic e_fault);
        vec_t t;
        t.name = name;       t.ifu_v = ifu_v;         t.pc = pc;
        t.jmp = jmp;         t.req_rdy = req_rdy;     t.rsp_v = rsp_v;
        t.rsp_d = rsp_d;     t.rsp_e = rsp_e;         t.idu_rdy = idu_rdy;
        t.e_ifu_rdy = e_ifu_rdy; t.e_req_v = e_req_v; t.e_addr = e_addr;
        t.e_idu_v = e_idu_v; t.e_pc = e_pc;           t.e_inst = e_inst;
        t.e_fault = e_fault;
        return t;
    endfunction

    // Address is only meaningful while a request is up, IDU payload only while valid.
    task automatic run_vec(input vec_t t);
        logic ok;
        i_ifu_valid      = t.ifu_v;
        i_ifu_pc         = t.pc;
        i_exu_jmp_en     = t.jmp;
        i_imem_req_ready = t.req_rdy;
        i_imem_rsp_valid = t.rsp_v;
        i_imem_rsp_data  = t.rsp_d;
        i_imem_rsp_err   = t.rsp_e;
        i_idu_ready      = t.idu_rdy;
        @(negedge i_sys_clk);
        ok = (o_ifu_ready === t.e_ifu_rdy) && (o_imem_req_valid === t.e_req_v) &&
             (!t.e_req_v || (o_imem_req_addr === t.e_addr)) && (o_idu_valid === t.e_idu_v) &&
             (!t.e_idu_v || ((o_idu_pc === t.e_pc) && (o_idu_inst === t.e_inst) &&
                             (o_idu_fault === t.e_fault)));
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got rdy=%b req=%b addr=%h idu=%b pc=%h inst=%h flt=%b; want rdy=%b req=%b addr=%h idu=%b pc=%h inst=%h flt=%b",
                     t.name, o_ifu_ready, o_imem_req_valid, o_imem_req_addr, o_idu_valid, o_idu_pc,
                     o_idu_inst, o_idu_fault, t.e_ifu_rdy, t.e_req_v, t.e_addr, t.e_idu_v, t.e_pc,
                     t.e_inst, t.e_fault);
        end
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        logic ok;
        ok = (o_ifu_ready === 1'b1) && (o_imem_req_valid === 1'b0) && (o_idu_valid === 1'b0) &&
             (o_idu_fault === 1'b0) && (o_idu_pc === 32'h0) && (o_idu_inst === 32'h0) &&
             (o_imem_req_addr === 32'h0);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got rdy=%b req=%b idu=%b flt=%b pc=%h inst=%h addr=%h; want rdy=1 req=0 idu=0 flt=0 pc/inst/addr=0",
                     name, o_ifu_ready, o_imem_req_valid, o_idu_valid, o_idu_fault, o_idu_pc,
                     o_idu_inst, o_imem_req_addr);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Columns: ifu_v pc jmp req_rdy rsp_v rsp_d rsp_e idu_rdy | rdy req addr idu pc inst flt
        tbl.push_back(mk("al_acc",       1, 32'h8000_0000, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("al_req",       0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0000, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("al_wait",      0, 32'h0, 0, 1, 1, 32'h0000_0093, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("al_hold",      0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_0000, 32'h0000_0093, 0));
        tbl.push_back(mk("mis_acc",      1, 32'h8000_0002, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("mis_stall",    0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h8000_0002, 32'h0000_0013, 1));
        tbl.push_back(mk("mis_xfer",     1, 32'h8000_0004, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_0002, 32'h0000_0013, 1));
        tbl.push_back(mk("err_req_stl",  0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0004, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("err_req",      0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0004, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("err_wait",     0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("err_rsp",      0, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("err_hold",     1, 32'h8000_0008, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_0004, 32'h0000_0013, 1));
        tbl.push_back(mk("fl_req",       0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0008, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_wait_jmp",  1, 32'h8000_0200, 1, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_idle",      1, 32'h8000_0100, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_req_blk",   0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_late_rsp",  0, 32'h0, 0, 1, 1, 32'h0000_0BAD, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_req_new",   0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0100, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_wait_new",  0, 32'h0, 0, 1, 1, 32'h0000_0113, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("fl_hold",      0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_0100, 32'h0000_0113, 0));
        tbl.push_back(mk("rq_acc",       1, 32'h8000_0300, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rq_jmp_fire",  0, 32'h0, 1, 1, 0, 32'h0, 0, 1, 1, 1, 32'h8000_0300, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rq_idle",      1, 32'h8000_0400, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rq_orph_rsp",  0, 32'h0, 0, 1, 1, 32'h0000_0BAD, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rq_req",       0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_0400, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rq_wait",      0, 32'h0, 0, 1, 1, 32'h0000_0513, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk("rq_hold",      0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_0400, 32'h0000_0513, 0));
        tbl.push_back(mk("rq_idle2",     0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));

        repeat (2) @(posedge i_sys_clk);
        @(negedge i_sys_clk);
        check_reset("reset_state");
        @(posedge i_sys_clk);
        #1;
        i_sys_rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Timeout: 5 WAIT cycles, then a faulted NOP; the stray response clears the orphan.
        run_vec(mk("to_acc",   1, 32'h8000_1000, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("to_req",   0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_1000, 0, 32'h0, 32'h0, 0));
        for (int k = 0; k < 5; k++)
            run_vec(mk("to_wait", 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("to_hold",  0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_1000, 32'h0000_0013, 1));
        run_vec(mk("to_stray", 0, 32'h0, 0, 1, 1, 32'h0000_0BAD, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("to_acc2",  1, 32'h8000_1004, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("to_req2",  0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_1004, 0, 32'h0, 32'h0, 0));
        run_vec(mk("to_wait2", 0, 32'h0, 0, 1, 1, 32'h0000_0613, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("to_hold2", 0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 1, 32'h8000_1004, 32'h0000_0613, 0));

        // Backpressure in HOLD for 4 cycles, then a flush while still stalled.
        run_vec(mk("bp_acc",   1, 32'h8000_2000, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("bp_req",   0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_2000, 0, 32'h0, 32'h0, 0));
        run_vec(mk("bp_wait",  0, 32'h0, 0, 1, 1, 32'h0000_0713, 0, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        for (int k = 0; k < 4; k++)
            run_vec(mk("bp_stall", 1, 32'h8000_3000, 0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h8000_2000, 32'h0000_0713, 0));
        run_vec(mk("bp_flush", 0, 32'h0, 1, 1, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("bp_idle",  0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));

        // Asynchronous reset in the middle of a WAIT.
        run_vec(mk("mr_acc",   1, 32'h8000_5000, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("mr_req",   0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_5000, 0, 32'h0, 32'h0, 0));
        #2;
        i_sys_rst = 1'b1;
        #1;
        check_reset("mid_reset");
        @(posedge i_sys_clk);
        #1;
        i_sys_rst = 1'b0;
        run_vec(mk("mr_acc2",  1, 32'h8000_6000, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 32'h0, 32'h0, 0));
        run_vec(mk("mr_req2",  0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 1, 32'h8000_6000, 0, 32'h0, 32'h0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch-request stage sitting directly downstream of the PC-generating IFU and upstream of the IDU. It accepts one PC at a time from the IFU, issues a single-outstanding read on the instruction-memory bus, and presents {pc, inst, fault} to the IDU with a valid/ready handshake. It handles EXU redirect flushes, misaligned PCs and bus timeouts without losing bus-response ordering.

## Interface
- `ADDR_W`, default 32: PC / bus address width.
- `INST_W`, default 32: instruction width.
- `TIMEOUT_CYC`, default 255: max cycles spent in WAIT before a fault is reported.
- `NOP_INST`, default 32'h0000_0013: instruction emitted with any fault.

Ports:
- `i_sys_clk`, in, 1: clock; all state updates on the rising edge.
- `i_sys_rst`, in, 1: reset, asynchronous, active-high.
- `i_ifu_valid`, in, 1: IFU presents a PC.
- `o_ifu_ready`, out, 1: block accepts the PC. Drives the IFU's `i_sys_ready`.
- `i_ifu_pc`, in, ADDR_W: fetch address.
- `i_exu_jmp_en`, in, 1: redirect/flush pulse from EXU.
- `o_imem_req_valid`, out, 1: bus read request.
- `i_imem_req_ready`, in, 1: bus accepts the request.
- `o_imem_req_addr`, out, ADDR_W: request address.
- `i_imem_rsp_valid`, in, 1: read data returned.
- `i_imem_rsp_data`, in, INST_W: read data.
- `i_imem_rsp_err`, in, 1: bus error on this response.
- `o_idu_valid`, out, 1: instruction available to IDU.
- `i_idu_ready`, in, 1: IDU consumes it.
- `o_idu_pc`, out, ADDR_W: PC of the instruction.
- `o_idu_inst`, out, INST_W: instruction, or NOP_INST on fault.
- `o_idu_fault`, out, 1: misaligned PC, bus error or timeout.

## Operation
- State: FSM with IDLE, REQ, WAIT and HOLD; `r_pc`, `r_inst`, `r_fault`; timeout counter `r_tmo` ($clog2(TIMEOUT_CYC+1) bits); orphan flag `r_orphan` (one bus response still owed and must be discarded).
- `o_ifu_ready` = (IDLE) | (HOLD & i_idu_ready) | i_exu_jmp_en.
- Flush (`i_exu_jmp_en`) has priority over every other event.
  - A PC accepted in the flush cycle is discarded.
  - The next state is IDLE.
  - HOLD content is dropped.
- IDLE / HOLD-with-transfer, on accept (no flush):
  - Latch `r_pc`.
  - If pc[1:0] != 0: go to HOLD with fault=1, inst=NOP_INST, and no bus request.
  - Otherwise: go to REQ.
- REQ: `o_imem_req_valid` = ~r_orphan; addr = r_pc.
  - On valid & req_ready: go to WAIT and clear `r_tmo`.
  - On flush in REQ: if the request is accepted that same cycle, set `r_orphan`. Otherwise abandon the request.
- WAIT: `r_tmo` increments each cycle.
  - On rsp_valid: latch data and err; fault = err; inst = err ? NOP_INST : data; go to HOLD.
  - On `r_tmo` == TIMEOUT_CYC with no rsp: go to HOLD with fault=1 and inst=NOP_INST, and set `r_orphan`.
  - On flush without rsp that cycle: set `r_orphan`.
  - On flush with rsp that same cycle: discard the response; `r_orphan` is not set.
- Orphan handling: any rsp_valid while `r_orphan`=1 is discarded and clears `r_orphan`. Discard takes precedence over WAIT capture, which cannot occur because REQ is blocked while `r_orphan`=1.
- HOLD: `o_idu_valid` = HOLD & ~i_exu_jmp_en.
  - On transfer: go to IDLE, or directly to REQ/HOLD if a new PC is accepted in the same cycle.
- Outputs `o_idu_*` and `o_imem_req_addr` are registered values.

## Timing
- Reset values: state IDLE; `o_imem_req_valid`=0, `o_idu_valid`=0, `o_idu_fault`=0; `o_idu_pc`=0, `o_idu_inst`=0, `o_imem_req_addr`=0; `r_orphan`=0, `r_tmo`=0; `o_ifu_ready`=1 (combinational from IDLE).
- Reset mid-transaction: any pending response is not tracked. The bus is reset in the same domain.
- Latency for a zero-wait-state bus (req_ready=1, rsp one cycle after accept):
  - Accept in cycle 0, REQ in cycle 1, WAIT in cycle 2 with rsp, HOLD in cycle 3.
  - Back-to-back throughput is one instruction per 3 cycles with i_idu_ready held high.
- Misaligned PC: HOLD is reached one cycle after accept.
- `o_idu_*` hold stable while `o_idu_valid`=1 and `i_idu_ready`=0.
- `o_imem_req_valid` may deassert before acceptance only on flush.

## Test plan
- Aligned fetch: pc=0x8000_0000; rsp data=0x0000_0093 one cycle after accept.
  - Expect o_idu_valid in cycle 3 with pc=0x8000_0000, inst=0x0000_0093, fault=0.
- Misaligned pc=0x8000_0002: no o_imem_req_valid ever.
  - Expect HOLD the next cycle with fault=1 and inst=0x0000_0013.
- Bus error: rsp_err=1 with data=0xDEAD_BEEF.
  - Expect fault=1 and inst=0x0000_0013.
- Flush in WAIT: jmp_en pulses in WAIT; rsp arrives 3 cycles later; next PC 0x8000_0100 is accepted.
  - Expect the late rsp discarded, no request for 0x8000_0100 until after that rsp, and 0x8000_0100 delivered with its own data.
- Timeout with TIMEOUT_CYC=4, no rsp:
  - Expect HOLD with fault=1 after 5 WAIT cycles.
  - A later stray rsp is dropped and clears orphan, and the next fetch then proceeds normally.
- Backpressure plus flush in HOLD: i_idu_ready=0 for 4 cycles, then jmp_en.
  - Expect outputs stable during the stall, o_idu_valid=0 in the flush cycle, and o_ifu_ready=1 in the flush cycle.
